// File: rtl/midi_parser.sv
// rtl/midi_parser.sv - MIDI byte-stream parser producing channel-voice event pulses
module midi_parser #(
    parameter logic [15:0] CHAN_MASK      = 16'hFFFF,
    parameter bit          RUNNING_STATUS = 1'b1,
    parameter bit          VEL0_IS_OFF    = 1'b1,
    parameter logic [13:0] PB_RESET       = 14'h2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        ev_valid,
    output logic [2:0]  ev_type,
    output logic [3:0]  ev_chan,
    output logic [6:0]  ev_d1,
    output logic [6:0]  ev_d2,
    output logic [13:0] ev_pb,
    output logic        rt_valid,
    output logic [2:0]  rt_code,
    output logic        sysex_active,
    output logic        err_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    state_t      r_state, w_state_nx;
    logic [7:0]  r_status, w_status_nx;
    logic        r_run_valid, w_run_nx;
    logic [6:0]  r_d1, w_d1_nx;

    logic        w_take_d1;
    logic        w_complete;
    logic [6:0]  w_cd1, w_cd2;
    logic [2:0]  w_type;
    logic        w_accept;
    logic        w_err;
    logic        w_rt;

    always_comb begin
        w_state_nx  = r_state;
        w_status_nx = r_status;
        w_run_nx    = r_run_valid;
        w_d1_nx     = r_d1;
        w_take_d1   = 1'b0;
        w_complete  = 1'b0;
        w_cd1       = 7'd0;
        w_cd2       = 7'd0;
        w_err       = 1'b0;
        w_rt        = 1'b0;
        if (byte_valid) begin
            if (byte_data >= 8'hF8) begin
                w_rt = 1'b1;
            end else if (byte_data[7] && (byte_data < 8'hF0)) begin
                w_status_nx = byte_data;
                w_run_nx    = 1'b1;
                w_state_nx  = WAIT_D1;
                w_err       = (r_state == WAIT_D1) || (r_state == WAIT_D2);
            end else if (byte_data == 8'hF0) begin
                w_run_nx   = 1'b0;
                w_state_nx = SYSEX;
            end else if (byte_data == 8'hF7) begin
                if (r_state == SYSEX)
                    w_state_nx = IDLE;
            end else if (byte_data[7]) begin
                w_run_nx   = 1'b0;
                w_state_nx = IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (RUNNING_STATUS && r_run_valid)
                            w_take_d1 = 1'b1;
                        else
                            w_err = 1'b1;
                    end
                    WAIT_D1: w_take_d1 = 1'b1;
                    WAIT_D2: begin
                        w_complete = 1'b1;
                        w_cd1      = r_d1;
                        w_cd2      = byte_data[6:0];
                    end
                    default: ;
                endcase
                // Program change (Cx) and channel pressure (Dx) carry a single data byte
                if (w_take_d1) begin
                    if (r_status[6:5] == 2'b10) begin
                        w_complete = 1'b1;
                        w_cd1      = byte_data[6:0];
                    end else begin
                        w_d1_nx    = byte_data[6:0];
                        w_state_nx = WAIT_D2;
                    end
                end
                if (w_complete) begin
                    if (RUNNING_STATUS) begin
                        w_state_nx = WAIT_D1;
                    end else begin
                        w_state_nx = IDLE;
                        w_run_nx   = 1'b0;
                    end
                end
            end
        end
        w_type = r_status[6:4];
        if (VEL0_IS_OFF && (w_type == 3'd1) && (w_cd2 == 7'd0))
            w_type = 3'd0;
        w_accept = w_complete && CHAN_MASK[r_status[3:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_status    <= 8'd0;
            r_run_valid <= 1'b0;
            r_d1        <= 7'd0;
        end else begin
            r_state     <= w_state_nx;
            r_status    <= w_status_nx;
            r_run_valid <= w_run_nx;
            r_d1        <= w_d1_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_valid     <= 1'b0;
            ev_type      <= 3'd0;
            ev_chan      <= 4'd0;
            ev_d1        <= 7'd0;
            ev_d2        <= 7'd0;
            ev_pb        <= PB_RESET;
            rt_valid     <= 1'b0;
            rt_code      <= 3'd0;
            sysex_active <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            ev_valid     <= w_accept;
            rt_valid     <= w_rt;
            err_pulse    <= w_err;
            sysex_active <= (w_state_nx == SYSEX);
            if (w_rt)
                rt_code <= byte_data[2:0];
            if (w_accept) begin
                ev_type <= w_type;
                ev_chan <= r_status[3:0];
                ev_d1   <= w_cd1;
                ev_d2   <= w_cd2;
                if (w_type == 3'd6)
                    ev_pb <= {w_cd2, w_cd1};
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// tb/tb_midi_parser.sv - directed bench for midi_parser (default, no-running-status, masked)
module tb_midi_parser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;

    logic        a_ev_valid, b_ev_valid, c_ev_valid;
    logic [2:0]  a_ev_type, b_ev_type, c_ev_type;
    logic [3:0]  a_ev_chan, b_ev_chan, c_ev_chan;
    logic [6:0]  a_ev_d1, b_ev_d1, c_ev_d1;
    logic [6:0]  a_ev_d2, b_ev_d2, c_ev_d2;
    logic [13:0] a_ev_pb, b_ev_pb, c_ev_pb;
    logic        a_rt_valid, b_rt_valid, c_rt_valid;
    logic [2:0]  a_rt_code, b_rt_code, c_rt_code;
    logic        a_sysex, b_sysex, c_sysex;
    logic        a_err, b_err, c_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    midi_parser u_a (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .ev_valid(a_ev_valid), .ev_type(a_ev_type), .ev_chan(a_ev_chan), .ev_d1(a_ev_d1),
        .ev_d2(a_ev_d2), .ev_pb(a_ev_pb), .rt_valid(a_rt_valid), .rt_code(a_rt_code),
        .sysex_active(a_sysex), .err_pulse(a_err)
    );

    midi_parser #(.RUNNING_STATUS(1'b0)) u_b (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .ev_valid(b_ev_valid), .ev_type(b_ev_type), .ev_chan(b_ev_chan), .ev_d1(b_ev_d1),
        .ev_d2(b_ev_d2), .ev_pb(b_ev_pb), .rt_valid(b_rt_valid), .rt_code(b_rt_code),
        .sysex_active(b_sysex), .err_pulse(b_err)
    );

    midi_parser #(.CHAN_MASK(16'hFFFB)) u_c (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .ev_valid(c_ev_valid), .ev_type(c_ev_type), .ev_chan(c_ev_chan), .ev_d1(c_ev_d1),
        .ev_d2(c_ev_d2), .ev_pb(c_ev_pb), .rt_valid(c_rt_valid), .rt_code(c_rt_code),
        .sysex_active(c_sysex), .err_pulse(c_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte is sampled on the next rising edge; outputs are inspected 1 ns later.
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ev_valid", a_ev_valid, 0);
        chk("rst_ev_type", a_ev_type, 0);
        chk("rst_ev_d1", a_ev_d1, 0);
        chk("rst_ev_pb", a_ev_pb, 14'h2000);
        chk("rst_sysex", a_sysex, 0);
        chk("rst_rt_code", a_rt_code, 0);
        chk("rst_err", a_err, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();

        // 93 3C 64: note-on chan 3
        send(8'h93); chk("t1_93_ev", a_ev_valid, 0); chk("t1_93_err", a_err, 0);
        send(8'h3C); chk("t1_3c_ev", a_ev_valid, 0);
        send(8'h64);
        chk("t1_ev", a_ev_valid, 1);
        chk("t1_type", a_ev_type, 1);
        chk("t1_chan", a_ev_chan, 3);
        chk("t1_d1", a_ev_d1, 7'h3C);
        chk("t1_d2", a_ev_d2, 7'h64);
        chk("t1_err", a_err, 0);
        chk("t1_mask_pass", c_ev_valid, 1);
        idle_cycle();
        chk("t1_ev_drop", a_ev_valid, 0);
        chk("t1_d1_hold", a_ev_d1, 7'h3C);

        // 90 3C 64 3E 00: running status and velocity-0 note-off
        pulse_reset(); idle_cycle();
        send(8'h90); send(8'h3C); send(8'h64);
        chk("t2_on_ev", a_ev_valid, 1);
        chk("t2_on_type", a_ev_type, 1);
        chk("t2_b_on_ev", b_ev_valid, 1);
        send(8'h3E);
        chk("t2_3e_ev", a_ev_valid, 0);
        chk("t2_3e_err", a_err, 0);
        chk("t2_b_3e_err", b_err, 1);
        send(8'h00);
        chk("t2_off_ev", a_ev_valid, 1);
        chk("t2_off_type", a_ev_type, 0);
        chk("t2_off_d1", a_ev_d1, 7'h3E);
        chk("t2_off_d2", a_ev_d2, 0);
        chk("t2_b_00_ev", b_ev_valid, 0);
        chk("t2_b_type_hold", b_ev_type, 1);

        // 90 F8 3C FA 64: interleaved real-time bytes
        pulse_reset(); idle_cycle();
        send(8'h90);
        send(8'hF8); chk("t3_rt1", a_rt_valid, 1); chk("t3_code1", a_rt_code, 0);
        send(8'h3C); chk("t3_rt1_drop", a_rt_valid, 0); chk("t3_mid_ev", a_ev_valid, 0);
        send(8'hFA); chk("t3_rt2", a_rt_valid, 1); chk("t3_code2", a_rt_code, 2);
        send(8'h64);
        chk("t3_ev", a_ev_valid, 1);
        chk("t3_d1", a_ev_d1, 7'h3C);
        chk("t3_d2", a_ev_d2, 7'h64);
        send(8'hFF); chk("t3_rt_after_ev", a_rt_valid, 1); chk("t3_ev_drop", a_ev_valid, 0);
        chk("t3_code3", a_rt_code, 7);

        // F0 7E 01 F7 C5 07: SysEx skip then program change
        pulse_reset(); idle_cycle();
        send(8'hF0); chk("t4_sx_f0", a_sysex, 1);
        send(8'h7E); chk("t4_sx_7e", a_sysex, 1); chk("t4_err_7e", a_err, 0);
        send(8'h01); chk("t4_sx_01", a_sysex, 1);
        send(8'hF7); chk("t4_sx_f7", a_sysex, 0);
        send(8'hC5); chk("t4_err_c5", a_err, 0);
        send(8'h07);
        chk("t4_ev", a_ev_valid, 1);
        chk("t4_type", a_ev_type, 4);
        chk("t4_chan", a_ev_chan, 5);
        chk("t4_d1", a_ev_d1, 7'h07);
        chk("t4_d2", a_ev_d2, 0);
        chk("t4_err", a_err, 0);

        // E2 00 40 / E2 7F 7F: pitch bend, and channel 2 masked on u_c
        pulse_reset(); idle_cycle();
        send(8'hE2); send(8'h00); send(8'h40);
        chk("t5_ev", a_ev_valid, 1);
        chk("t5_type", a_ev_type, 6);
        chk("t5_chan", a_ev_chan, 2);
        chk("t5_pb", a_ev_pb, 14'h2000);
        chk("t5_mask_ev", c_ev_valid, 0);
        chk("t5_mask_err", c_err, 0);
        pulse_reset(); idle_cycle();
        send(8'hE2); send(8'h7F); send(8'h7F);
        chk("t5b_ev", a_ev_valid, 1);
        chk("t5b_pb", a_ev_pb, 14'h3FFF);
        chk("t5b_mask_ev", c_ev_valid, 0);
        chk("t5b_mask_pb", c_ev_pb, 14'h2000);
        send(8'hB0); send(8'h07); send(8'h10);
        chk("t5c_cc_type", a_ev_type, 3);
        chk("t5c_pb_hold", a_ev_pb, 14'h3FFF);

        // 90 3C, asynchronous reset, 40: partial message lost
        pulse_reset(); idle_cycle();
        send(8'h90); send(8'h3C);
        #2;
        pulse_reset();
        chk("t6_pb_rst", a_ev_pb, 14'h2000);
        chk("t6_type_rst", a_ev_type, 0);
        send(8'h40);
        chk("t6_ev", a_ev_valid, 0);
        chk("t6_err", a_err, 1);

        // F1 clears running status
        pulse_reset(); idle_cycle();
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'hF1); chk("t7_f1_err", a_err, 0);
        send(8'h3C); chk("t7_err", a_err, 1); chk("t7_ev", a_ev_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/midi_parser.md
# midi_parser

Parametrised MIDI byte-stream parser that turns a UART-delivered MIDI byte stream into single-cycle channel-voice event pulses for the synth voice allocators. It handles all seven channel-voice message types, running status, interleaved real-time bytes, SysEx skipping and a per-channel accept mask. It sits between the MIDI UART receiver and the note/CC/pitch-bend consumers.

## Interface
Parameters:
- CHAN_MASK, 16'hFFFF, bit n = 1 accepts MIDI channel n; events on masked channels are silently dropped.
- RUNNING_STATUS, 1, 1 = honour running status; 0 = a data byte with no fresh status is an error.
- VEL0_IS_OFF, 1, 1 = note-on with velocity 0 is reported as note-off.
- PB_RESET, 14'h2000, reset value of ev_pb.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- byte_valid  in  1  byte_data is valid this cycle; one byte is consumed per asserted cycle.
- byte_data  in  8  received MIDI byte.
- ev_valid  out  1  one-cycle pulse: a complete, accepted channel-voice event.
- ev_type  out  3  0 note-off, 1 note-on, 2 poly aftertouch, 3 CC, 4 program change, 5 channel pressure, 6 pitch bend.
- ev_chan  out  4  event channel.
- ev_d1  out  7  first data byte: note / CC number / program / pressure / PB LSB.
- ev_d2  out  7  second data byte; 0 for 2-byte messages.
- ev_pb  out  14  {MSB,LSB}; updated only on pitch-bend events, otherwise held.
- rt_valid  out  1  one-cycle pulse for a real-time byte (F8-FF).
- rt_code  out  3  byte_data[2:0] of that real-time byte.
- sysex_active  out  1  high while inside F0..F7.
- err_pulse  out  1  one-cycle pulse on protocol error.

## Operation
- States: IDLE (no usable status), WAIT_D1, WAIT_D2, SYSEX. Registers: status byte, running-valid flag, D1 latch.
- Only bytes with byte_valid=1 are processed; all other cycles leave state unchanged.
- Real-time byte F8-FF in any state: rt_valid pulse, rt_code=byte[2:0]. State, status, D1 latch and sysex_active are untouched.
- Status 80-EF in any state: latch status, set running-valid, go to WAIT_D1. If previously in WAIT_D1/WAIT_D2, the partial message is discarded and err_pulse fires. If in SYSEX, the SysEx ends with no error.
- F0: clear running-valid, go to SYSEX, set sysex_active. F7 in SYSEX: go to IDLE, clear sysex_active. F7 outside SYSEX: ignored.
- F1-F6: clear running-valid and go to IDLE; any following data bytes are handled as in IDLE.
- Data byte (bit7=0) handling:
  - IDLE: if RUNNING_STATUS and running-valid, treat the byte as D1 (running status). Otherwise discard it and pulse err_pulse.
  - SYSEX: discard the byte, no error.
  - WAIT_D1: status Cx or Dx completes the message (d2=0). Any other status latches D1 and goes to WAIT_D2.
  - WAIT_D2: completes the message.
- After completion: go to WAIT_D1 if RUNNING_STATUS=1, else go to IDLE and clear running-valid.
- Completion with CHAN_MASK[chan]=0: no ev_valid and no error; the state transitions still happen.
- Note-on (9x) with d2=0 and VEL0_IS_OFF: ev_type=0, ev_d2=0.
- Pitch bend: ev_pb = {d2, d1}.

## Timing
- All outputs are registered. ev_valid, rt_valid and err_pulse assert exactly one cycle, on the cycle after the completing/offending byte is sampled.
- ev_type, ev_chan, ev_d1, ev_d2 and ev_pb are stable from the ev_valid cycle until the next event.
- The parser accepts back-to-back bytes every cycle; there is no backpressure.
- A real-time byte arriving the cycle after a completing byte produces rt_valid one cycle after ev_valid. No pulse is ever lost.
- Reset (asynchronous, any time, including mid-message or mid-SysEx):
  - state IDLE, running-valid 0;
  - all pulses 0, ev_type/ev_chan/ev_d1/ev_d2 0, ev_pb=PB_RESET, sysex_active 0, rt_code 0;
  - the partial message is lost.

## Test plan
- Bytes 93 3C 64 -> one ev_valid, type 1, chan 3, d1 3C, d2 64; no err.
- 90 3C 64 3E 00 (RUNNING_STATUS=1, VEL0_IS_OFF=1) -> two events: note-on 3C/64, then note-off 3E/00. With RUNNING_STATUS=0 -> one event, then err_pulse on 3E, 00 discarded.
- 90 F8 3C FA 64 -> rt_valid with code 0, then code 2; a single note-on 3C/64, unaffected by the interleaving.
- F0 7E 01 F7 C5 07 -> sysex_active high from F0 through F7; one event type 4, chan 5, d1 07, d2 0; no err.
- E2 00 40 -> type 6, ev_pb 14'h2000. E2 7F 7F -> ev_pb 14'h3FFF. CHAN_MASK=16'hFFFB: same stream -> no ev_valid.
- 90 3C then reset pulse then 40 -> no event; err_pulse on 40; ev_pb=PB_RESET after reset.
